// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: one shared resource, N_REQ requesters, grant held until release or timeout.
// Latency: 1 cycle from sampled request to registered grant; at least one idle cycle between grants.
// Backpressure: none; the owner holds the grant by keeping its request high, at most MAX_HOLD cycles.
module rr_grant_arbiter #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] grant_oh,
    output logic             timeout_pulse
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    logic             owner_req;

    // Scan from the farthest slot back to ptr so the closest request (in circular order) wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[ptr + IDX_W'(k)]) begin
                win_vld = 1'b1;
                win_idx = ptr + IDX_W'(k);
            end
        end
    end

    assign owner_req = req[grant_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant_valid   <= 1'b0;
            grant_idx     <= '0;
            grant_oh      <= '0;
            timeout_pulse <= 1'b0;
            ptr           <= '0;
            hold_cnt      <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en && win_vld) begin
                        state       <= GRANT;
                        grant_valid <= 1'b1;
                        grant_idx   <= win_idx;
                        grant_oh    <= N_REQ'(1) << win_idx;
                        hold_cnt    <= '0;
                    end
                end
                GRANT: begin
                    // A dropped request on the timeout edge counts as a normal release.
                    if (!owner_req || hold_cnt == HOLD_LAST) begin
                        state         <= IDLE;
                        grant_valid   <= 1'b0;
                        grant_idx     <= '0;
                        grant_oh      <= '0;
                        hold_cnt      <= '0;
                        ptr           <= grant_idx + IDX_W'(1);
                        timeout_pulse <= owner_req;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter with MAX_HOLD=4: directed scenarios plus random traffic against a reference model.
module tb_rr_grant_arbiter;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] req = 8'h00;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] grant_oh;
    logic       timeout_pulse;

    int total  = 0;
    int passed = 0;

    rr_grant_arbiter #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(MAXH), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .req          (req),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_oh     (grant_oh),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: owner (-1 = none), rotation start, cycles the grant has been visible.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_pulse = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_pulse = 1'b0;
        end else if (m_owner < 0) begin
            m_pulse = 1'b0;
            if (en && req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
                end
                m_held = 1;
            end
        end else if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % 8; m_owner = -1; m_held = 0; m_pulse = 1'b0;
        end else if (m_held == MAXH) begin
            m_ptr = (m_owner + 1) % 8; m_owner = -1; m_held = 0; m_pulse = 1'b1;
        end else begin
            m_held = m_held + 1;
        end
    end

    function automatic logic [12:0] model_vec();
        logic [12:0] v;
        if (m_owner >= 0) v = {1'b1, 3'(m_owner), 8'(1 << m_owner), m_pulse};
        else              v = {1'b0, 3'd0, 8'h00, m_pulse};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; req = 8'h00;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = 8'hFF;
        step();
        step();
        total++;
        if ({grant_valid, grant_idx, grant_oh, timeout_pulse} !== 13'd0)
            $display("FAIL reset_outputs: got %b want all zero", {grant_valid, grant_idx, grant_oh, timeout_pulse});
        else passed++;
        rst = 1'b0; req = 8'h00; en = 1'b0;
        step();
    endtask

    task automatic test_basic();
        do_reset();
        req = 8'h01; en = 1'b1;
        step();
        total++;
        if ({grant_valid, grant_idx, grant_oh} !== {1'b1, 3'd0, 8'h01})
            $display("FAIL basic_grant: got v=%b idx=%0d oh=%h want v=1 idx=0 oh=01", grant_valid, grant_idx, grant_oh);
        else passed++;
        req = 8'h00;
        step();
        total++;
        if ({grant_valid, grant_idx, grant_oh, timeout_pulse} !== 13'd0)
            $display("FAIL basic_release: got %b want all zero", {grant_valid, grant_idx, grant_oh, timeout_pulse});
        else passed++;
        // ptr is now 1, so requester 1 beats requester 0
        req = 8'h03;
        step();
        total++;
        if ({grant_valid, grant_idx} !== {1'b1, 3'd1})
            $display("FAIL basic_ptr_advance: got v=%b idx=%0d want v=1 idx=1", grant_valid, grant_idx);
        else passed++;
        req = 8'h00;
        step();
    endtask

    task automatic test_rotation();
        int seq[$];
        int lens[$];
        int run = 0;
        int pulses = 0;
        do_reset();
        req = 8'hFF; en = 1'b1;
        for (int c = 0; c < 45; c++) begin
            step();
            total++;
            if ({grant_valid, grant_idx, grant_oh, timeout_pulse} !== model_vec())
                $display("FAIL rotation_cycle%0d: got %b want %b", c, {grant_valid, grant_idx, grant_oh, timeout_pulse}, model_vec());
            else passed++;
            if (grant_valid) begin
                if (run == 0) seq.push_back(int'(grant_idx));
                run++;
            end else if (run != 0) begin
                lens.push_back(run);
                run = 0;
            end
            if (timeout_pulse) pulses++;
        end
        total++;
        if (seq.size() != 9) $display("FAIL rotation_count: got %0d grants want 9", seq.size());
        else passed++;
        foreach (seq[i]) begin
            total++;
            if (seq[i] != i % 8) $display("FAIL rotation_order%0d: got %0d want %0d", i, seq[i], i % 8);
            else passed++;
        end
        foreach (lens[i]) begin
            total++;
            if (lens[i] != MAXH) $display("FAIL rotation_len%0d: got %0d want %0d", i, lens[i], MAXH);
            else passed++;
        end
        total++;
        if (pulses != 9) $display("FAIL rotation_pulses: got %0d want 9", pulses);
        else passed++;
        req = 8'h00;
        step();
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        req = 8'h20; en = 1'b1;
        step();
        total++;
        if (grant_idx !== 3'd5) $display("FAIL wrap_first: got idx=%0d want 5", grant_idx);
        else passed++;
        req = 8'h00;
        step();
        req = 8'h21;
        step();
        total++;
        if ({grant_valid, grant_idx, grant_oh} !== {1'b1, 3'd0, 8'h01})
            $display("FAIL wrap_grant: got v=%b idx=%0d oh=%h want v=1 idx=0 oh=01", grant_valid, grant_idx, grant_oh);
        else passed++;
        req = 8'h00;
        step();
    endtask

    task automatic test_enable_gating();
        int bad = 0;
        do_reset();
        en = 1'b0; req = 8'h10;
        for (int c = 0; c < 10; c++) begin
            step();
            if (grant_valid !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL enable_off: got %0d granted cycles want 0", bad);
        else passed++;
        en = 1'b1;
        step();
        total++;
        if ({grant_valid, grant_idx, grant_oh} !== {1'b1, 3'd4, 8'h10})
            $display("FAIL enable_on: got v=%b idx=%0d oh=%h want v=1 idx=4 oh=10", grant_valid, grant_idx, grant_oh);
        else passed++;
        en = 1'b0;
        step();
        step();
        total++;
        if ({grant_valid, grant_idx} !== {1'b1, 3'd4})
            $display("FAIL enable_mid_grant: got v=%b idx=%0d want v=1 idx=4", grant_valid, grant_idx);
        else passed++;
        req = 8'h00;
        step();
        total++;
        if ({grant_valid, timeout_pulse} !== 2'b00)
            $display("FAIL enable_release: got v=%b pulse=%b want 0 0", grant_valid, timeout_pulse);
        else passed++;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        en = 1'b1; req = 8'h04;
        step();
        req = 8'h00;
        step();
        req = 8'h08;
        step();
        total++;
        if (grant_idx !== 3'd3) $display("FAIL rstmid_owner: got idx=%0d want 3", grant_idx);
        else passed++;
        rst = 1'b1;
        step();
        total++;
        if ({grant_valid, grant_idx, grant_oh, timeout_pulse} !== 13'd0)
            $display("FAIL rstmid_outputs: got %b want all zero", {grant_valid, grant_idx, grant_oh, timeout_pulse});
        else passed++;
        rst = 1'b0; req = 8'h09;
        step();
        total++;
        if ({grant_valid, grant_idx, grant_oh} !== {1'b1, 3'd0, 8'h01})
            $display("FAIL rstmid_ptr: got v=%b idx=%0d oh=%h want v=1 idx=0 oh=01", grant_valid, grant_idx, grant_oh);
        else passed++;
        req = 8'h00;
        step();
    endtask

    task automatic test_simultaneous();
        int vis = 0;
        do_reset();
        en = 1'b1; req = 8'h04;
        for (int c = 0; c < MAXH; c++) begin
            step();
            if (grant_valid === 1'b1 && grant_idx === 3'd2) vis++;
        end
        req = 8'h00;
        step();
        total++;
        if (vis != MAXH) $display("FAIL simul_visible: got %0d cycles want %0d", vis, MAXH);
        else passed++;
        total++;
        if ({grant_valid, timeout_pulse} !== 2'b00)
            $display("FAIL simul_release: got v=%b pulse=%b want 0 0", grant_valid, timeout_pulse);
        else passed++;
        req = 8'h0C;
        step();
        total++;
        if ({grant_valid, grant_idx} !== {1'b1, 3'd3})
            $display("FAIL simul_ptr: got v=%b idx=%0d want v=1 idx=3", grant_valid, grant_idx);
        else passed++;
        req = 8'h00;
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            step();
            total++;
            if ({grant_valid, grant_idx, grant_oh, timeout_pulse} !== model_vec())
                $display("FAIL random_cycle%0d: got %b want %b", c, {grant_valid, grant_idx, grant_oh, timeout_pulse}, model_vec());
            else passed++;
        end
        rst = 1'b0; req = 8'h00;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_pointer_wrap();
        test_enable_gating();
        test_reset_mid_grant();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Produces a registered 3-bit grant index plus its one-hot decoded form.
- The one-hot output is the 3-to-8 decode of the index, so both are always consistent.
- A grant is held until the owner drops its request or a hold timeout forces rotation.
- Sits between the requesting units and the shared resource's select/enable lines.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8, must equal 2**IDX_W.
- IDX_W, 3, grant index width.
- MAX_HOLD, 16, maximum consecutive cycles a grant may be held; legal range 2..256.
- CNT_W, 8, hold counter width; must satisfy 2**CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; when 0, no new grant is issued.
- req  input  8  request vector; bit i = requester i wants the resource.
- grant_valid  output  1  a grant is currently active.
- grant_idx  output  3  index of the current owner; 0 when no grant.
- grant_oh  output  8  one-hot grant (1 << grant_idx) when grant_valid, else 8'h00.
- timeout_pulse  output  1  one-cycle pulse on the cycle after a forced (timeout) release.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All outputs are registered.
- Reset, sampled at a clk edge, sets: state=IDLE, grant_valid=0, grant_idx=0, grant_oh=0, timeout_pulse=0, ptr=0, hold_cnt=0.
- Reset mid-grant: applies at the next edge unconditionally; the grant is dropped and ptr returns to 0.
- Internal state: ptr (3-bit round-robin start point) and hold_cnt (CNT_W-bit).
- FSM state IDLE, edge with en=1 and req!=0:
  - Winner = first set req bit searching circularly ptr, ptr+1, ..., 7, 0, ..., ptr-1.
  - Next state GRANT; grant_valid=1, grant_idx=winner, grant_oh=decode(winner), hold_cnt=0.
  - Latency from sampled request to visible grant is exactly 1 cycle.
- FSM state IDLE, edge with en=0 or req==0: remain in IDLE; outputs stay 0.
- FSM state GRANT, normal release: at an edge with req[grant_idx]==0:
  - Next state IDLE; grant_valid=0, grant_idx=0, grant_oh=0.
  - ptr = grant_idx+1 mod 8 (7 wraps to 0).
  - timeout_pulse=0.
- FSM state GRANT, timeout release: at an edge with req[grant_idx]==1 and hold_cnt==MAX_HOLD-1:
  - Same as normal release, except timeout_pulse=1 for exactly one cycle.
  - grant_valid is therefore high for at most MAX_HOLD consecutive cycles.
- FSM state GRANT, otherwise: hold the grant and increment hold_cnt.
- Simultaneous timeout and request drop at the same edge: treated as a normal release; timeout_pulse=0.
- Bubble: every release is followed by at least one cycle with grant_valid=0. Re-arbitration happens in IDLE using the updated ptr.
- en during GRANT: ignored; an active grant continues and releases normally.
- Other req bits during GRANT: changes are ignored; only req[grant_idx] is monitored.
- Timeout holder: after a forced release, the holder is lowest priority in the next arbitration, but may win again if it is the only requester.
- Invariants:
  - grant_oh is zero or exactly one-hot.
  - grant_oh == (grant_valid ? 1<<grant_idx : 0) on every cycle.

Test Plan:
1. Basic grant: assert rst for 2 cycles, then req=8'h01, en=1.
   -> Cycle after sampling: grant_valid=1, grant_idx=0, grant_oh=8'h01.
   -> Drop req: next cycle all outputs 0; ptr=1.
2. Full rotation with timeout: MAX_HOLD=4, req=8'hFF held, en=1.
   -> Grants go 0,1,...,7,0. Each grant is 4 cycles long and separated by one idle cycle.
   -> timeout_pulse=1 on each idle cycle; grant_oh follows 01,02,04,...,80,01.
3. Pointer wrap: after releasing owner 5 normally (ptr=6), apply req=8'h21.
   -> Next grant idx=0 (search order 6,7,0), not 5; grant_oh=8'h01.
4. Enable gating: en=0 with req=8'h10.
   -> grant_valid stays 0 for 10 cycles.
   -> Set en=1: grant idx=4 one cycle later; set en=0 mid-grant: grant persists until req[4] drops.
5. Reset mid-grant: while owner idx=3, pulse rst for 1 cycle.
   -> Next edge: all outputs 0 and timeout_pulse=0.
   -> Then req=8'h09: grant idx=0, since ptr was reset to 0.
6. Simultaneous events: MAX_HOLD=4; owner 2 drops req on the same edge hold_cnt reaches 3.
   -> Normal release: timeout_pulse=0, ptr=3, grant was visible for exactly 4 cycles.
